// File: rtl/maze_player_mover_if.sv
`default_nettype none
// ============================================================================
// Module   : maze_player_mover_if
// Purpose  : Groups the input-handler, maze-RAM and renderer signals of the
//            player mover into one bundle.
// Revision : 1.0
// ============================================================================
interface maze_player_mover_if #(
    parameter int COORD_W = 8,
    parameter int ADDR_W  = 11
);
    logic [3:0]         player_direction;
    logic               at_start;
    logic               maze_input_data;
    logic [COORD_W-1:0] player_x;
    logic [COORD_W-1:0] player_y;
    logic [ADDR_W-1:0]  maze_input_address;
    logic               busy;
    logic [15:0]        move_count;
    logic               at_end;

    modport master (
        input  player_direction, at_start, maze_input_data,
        output player_x, player_y, maze_input_address, busy, move_count, at_end
    );

    modport slave (
        output player_direction, at_start, maze_input_data,
        input  player_x, player_y, maze_input_address, busy, move_count, at_end
    );
endinterface
`default_nettype wire

// File: rtl/maze_player_mover.sv
`default_nettype none
// ============================================================================
// Module   : maze_player_mover
// Purpose  : Turns one-hot direction presses into single-tile player moves
//            after checking the target tile in maze RAM.
//            Optional held-key auto-repeat: MAZE_MOVE_REPEAT_EN.
// Revision : 1.0
// ============================================================================
module maze_player_mover #(
    parameter int WIDTH        = 10,
    parameter int HEIGHT       = 10,
    parameter int COORD_W      = 8,
    parameter int ADDR_W       = 11,
    parameter int READ_LATENCY = 3,
    parameter int START_X      = 0,
    parameter int START_Y      = 0,
    parameter int EXIT_X       = WIDTH - 1,
    parameter int EXIT_Y       = HEIGHT - 1,
    parameter int REPEAT_DELAY = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    maze_player_mover_if.master bus
);

    localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    localparam logic [COORD_W-1:0] C_START_X = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] C_START_Y = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] C_EXIT_X  = COORD_W'(EXIT_X);
    localparam logic [COORD_W-1:0] C_EXIT_Y  = COORD_W'(EXIT_Y);
    localparam logic [COORD_W-1:0] C_MAX_X   = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] C_MAX_Y   = COORD_W'(HEIGHT - 1);
    localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);
    localparam logic [ADDR_W-1:0]  C_ROW     = ADDR_W'(WIDTH);
    localparam logic [LAT_W-1:0]   C_LAT     = LAT_W'(READ_LATENCY);
    localparam logic [LAT_W-1:0]   C_LAT_ONE = LAT_W'(1);

    localparam logic [3:0] C_DIR_UP    = 4'b0001;
    localparam logic [3:0] C_DIR_DOWN  = 4'b0010;
    localparam logic [3:0] C_DIR_RIGHT = 4'b0100;
    localparam logic [3:0] C_DIR_LEFT  = 4'b1000;

    generate
        if (WIDTH < 2 || HEIGHT < 2 || READ_LATENCY < 1 || REPEAT_DELAY < 1 ||
            WIDTH * HEIGHT > (1 << ADDR_W)) begin : g_bad_params
            $error("maze_player_mover: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [COORD_W-1:0] r_pos_x;
    logic [COORD_W-1:0] r_pos_y;
    logic [COORD_W-1:0] r_tgt_x;
    logic [COORD_W-1:0] r_tgt_y;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_busy;
    logic [15:0]        r_move_count;
    logic               r_at_end;
    logic [3:0]         r_prev_dir;
    logic [LAT_W-1:0]   r_lat_cnt;

    logic               w_in_bounds;
    logic               w_at_exit;
    logic               w_accept;
    logic [COORD_W-1:0] w_tgt_x;
    logic [COORD_W-1:0] w_tgt_y;
    logic [ADDR_W-1:0]  w_tgt_addr;

    // Bounds are judged before the step so the target can never wrap.
    always_comb begin
        w_in_bounds = 1'b0;
        w_tgt_x     = r_pos_x;
        w_tgt_y     = r_pos_y;
        case (bus.player_direction)
            C_DIR_UP: begin
                w_in_bounds = (r_pos_y != '0);
                w_tgt_y     = r_pos_y - C_ONE;
            end
            C_DIR_DOWN: begin
                w_in_bounds = (r_pos_y < C_MAX_Y);
                w_tgt_y     = r_pos_y + C_ONE;
            end
            C_DIR_RIGHT: begin
                w_in_bounds = (r_pos_x < C_MAX_X);
                w_tgt_x     = r_pos_x + C_ONE;
            end
            C_DIR_LEFT: begin
                w_in_bounds = (r_pos_x != '0);
                w_tgt_x     = r_pos_x - C_ONE;
            end
            default: w_in_bounds = 1'b0;
        endcase
    end

    assign w_at_exit  = (r_pos_x == C_EXIT_X) && (r_pos_y == C_EXIT_Y);
    assign w_accept   = w_in_bounds && (bus.player_direction != r_prev_dir);
    assign w_tgt_addr = C_ROW * ADDR_W'(w_tgt_y) + ADDR_W'(w_tgt_x);

`ifdef MAZE_MOVE_REPEAT_EN
    localparam int REP_W = (REPEAT_DELAY < 2) ? 1 : $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] C_REP     = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] C_REP_ONE = REP_W'(1);

    logic [REP_W-1:0] r_rep_timer;
    logic             r_rep_armed;
    logic [3:0]       r_dir_q;
    logic             w_oob_fresh;

    assign w_oob_fresh = $onehot(bus.player_direction) && !w_in_bounds &&
                         (bus.player_direction != r_prev_dir);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_pos_x      <= C_START_X;
            r_pos_y      <= C_START_Y;
            r_tgt_x      <= '0;
            r_tgt_y      <= '0;
            r_addr       <= '0;
            r_busy       <= 1'b0;
            r_move_count <= '0;
            r_at_end     <= 1'b0;
            r_prev_dir   <= '0;
            r_lat_cnt    <= '0;
`ifdef MAZE_MOVE_REPEAT_EN
            r_rep_timer  <= '0;
            r_rep_armed  <= 1'b0;
            r_dir_q      <= '0;
`endif
        end else begin
            r_at_end <= 1'b0;
`ifdef MAZE_MOVE_REPEAT_EN
            r_dir_q  <= bus.player_direction;
`endif
            if (bus.at_start) begin
                // Address holds; any read in flight is simply abandoned.
                r_state      <= IDLE;
                r_pos_x      <= C_START_X;
                r_pos_y      <= C_START_Y;
                r_busy       <= 1'b0;
                r_move_count <= '0;
                r_prev_dir   <= '0;
                r_lat_cnt    <= '0;
`ifdef MAZE_MOVE_REPEAT_EN
                r_rep_timer  <= '0;
                r_rep_armed  <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_at_exit) begin
                            r_at_end   <= 1'b1;
                            r_pos_x    <= C_START_X;
                            r_pos_y    <= C_START_Y;
                            r_prev_dir <= bus.player_direction;
                            r_state    <= DONE;
`ifdef MAZE_MOVE_REPEAT_EN
                            r_rep_armed <= 1'b0;
`endif
                        end else if (w_accept) begin
                            r_addr    <= w_tgt_addr;
                            r_tgt_x   <= w_tgt_x;
                            r_tgt_y   <= w_tgt_y;
                            r_busy    <= 1'b1;
                            r_lat_cnt <= C_LAT_ONE;
                            r_state   <= WAIT;
`ifdef MAZE_MOVE_REPEAT_EN
                            r_rep_armed <= 1'b0;
`endif
                        end else begin
                            r_prev_dir <= bus.player_direction;
`ifdef MAZE_MOVE_REPEAT_EN
                            if (w_oob_fresh) begin
                                r_rep_armed <= 1'b1;
                                r_rep_timer <= C_REP_ONE;
                            end else if (r_rep_armed) begin
                                if (bus.player_direction != r_dir_q) begin
                                    r_rep_timer <= C_REP_ONE;
                                end else if (r_rep_timer == C_REP) begin
                                    r_rep_armed <= 1'b0;
                                    if ($onehot(bus.player_direction)) begin
                                        r_prev_dir <= '0;
                                    end
                                end else begin
                                    r_rep_timer <= r_rep_timer + C_REP_ONE;
                                end
                            end
`endif
                        end
                    end
                    WAIT: begin
                        if (r_lat_cnt == C_LAT_ONE) begin
                            r_prev_dir <= bus.player_direction;
                        end
                        if (r_lat_cnt == C_LAT) begin
                            if (!bus.maze_input_data) begin
                                r_pos_x <= r_tgt_x;
                                r_pos_y <= r_tgt_y;
                                if (r_move_count != 16'hFFFF) begin
                                    r_move_count <= r_move_count + 16'd1;
                                end
                            end
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
`ifdef MAZE_MOVE_REPEAT_EN
                            r_rep_armed <= 1'b1;
                            r_rep_timer <= C_REP_ONE;
`endif
                        end else begin
                            r_lat_cnt <= r_lat_cnt + C_LAT_ONE;
                        end
                    end
                    DONE: begin
                        r_state <= DONE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.player_x           = r_pos_x;
    assign bus.player_y           = r_pos_y;
    assign bus.maze_input_address = r_addr;
    assign bus.busy               = r_busy;
    assign bus.move_count         = r_move_count;
    assign bus.at_end             = r_at_end;

endmodule
`default_nettype wire

// File: doc/maze_player_mover.md
Name: maze_player_mover

Overview:
- Parametrised successor to the maze input block. Turns debounced one-hot direction presses into single-tile player moves after checking the target tile in maze RAM.
- Sits between the input handler and the maze RAM read port. Drives the player position to the renderer and `at_end` to the game-flow FSM.
- New relative to the previous generation:
  - configurable grid, coordinate and address widths
  - configurable RAM read latency
  - configurable start and exit tiles
  - async reset
  - busy flag and saturating move counter
  - end-of-maze lockout until restart

Parameters:
- WIDTH, 10, maze width in tiles (≥2)
- HEIGHT, 10, maze height in tiles (≥2)
- COORD_W, 8, width of player_x/player_y
- ADDR_W, 11, maze RAM address width; WIDTH*HEIGHT ≤ 2^ADDR_W
- READ_LATENCY, 3, clock edges from address update to data sample (≥1)
- START_X, 0, start/restart tile x
- START_Y, 0, start/restart tile y
- EXIT_X, WIDTH-1, exit tile x
- EXIT_Y, HEIGHT-1, exit tile y
- REPEAT_DELAY, 8, held-key repeat interval in cycles (used only with the optional feature)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- player_direction  in  4  one-hot: bit0 UP, bit1 DOWN, bit2 RIGHT, bit3 LEFT
- at_start  in  1  synchronous restart, highest priority after reset
- maze_input_data  in  1  tile at maze_input_address: 0 floor, 1 wall
- player_x  out  COORD_W  current x
- player_y  out  COORD_W  current y
- maze_input_address  out  ADDR_W  registered RAM read address
- busy  out  1  high while a tile read is outstanding
- move_count  out  16  successful moves since start, saturating
- at_end  out  1  one-cycle pulse on reaching exit

Behaviour:
- Reset (reset_n low, async): all of the following hold until reset_n is released.
  - player_x=START_X, player_y=START_Y
  - maze_input_address=0, busy=0, move_count=0, at_end=0
  - prev_direction=0, state=IDLE
- at_start high at an edge: same values as reset, except maze_input_address holds. Takes priority over every state and aborts any outstanding read; late data is ignored.
- States: IDLE, WAIT, DONE.
- IDLE, edge E0: a move is accepted only if all hold:
  - direction is exactly one-hot
  - direction differs from prev_direction
  - target tile is in bounds: UP needs y>0, DOWN needs y<HEIGHT-1, LEFT needs x>0, RIGHT needs x<WIDTH-1
- On acceptance at E0:
  - maze_input_address <= WIDTH*ty + tx, computed at ADDR_W width
  - requested direction latched
  - busy <= 1, go to WAIT with latency counter=1
- Otherwise at E0: prev_direction <= player_direction, including for zero, multi-hot and out-of-bounds inputs. No RAM address change, busy stays 0.
- WAIT:
  - prev_direction <= player_direction at the first WAIT edge.
  - Counter increments each edge. At edge E0+READ_LATENCY, maze_input_data is sampled.
  - Floor: position updates to the target at that edge, move_count increments (saturates at 16'hFFFF).
  - Wall: no change.
  - Same edge: busy <= 0, state <= IDLE.
  - player_direction changes during WAIT are ignored, apart from the prev_direction capture.
- Exit detection: on the edge after the position equals (EXIT_X, EXIT_Y):
  - at_end <= 1 for exactly one cycle
  - position <= (START_X, START_Y)
  - state <= DONE
  - move_count frozen
- DONE: all direction inputs ignored, no RAM requests. Leave only via at_start or reset.
- Arithmetic: target coordinates are computed in COORD_W. Bounds are checked before the add/subtract, so no wrap-around is possible.

Optional Feature:
- Macro MAZE_MOVE_REPEAT_EN.
- Defined:
  - A direction held one-hot and unchanged re-arms automatically REPEAT_DELAY cycles after the edge at which its previous WAIT completed.
  - At that point prev_direction is cleared, so the next IDLE edge accepts the same direction again.
  - Any change of player_direction restarts the repeat timer.
  - A wall or out-of-bounds result still re-arms.
- Undefined: strictly one move per press; the direction must change (including to 0) before the same key moves again. The repeat timer is not synthesised.

Test Plan (WIDTH=10, HEIGHT=10, READ_LATENCY=3, START=(0,0), EXIT=(9,9)):
1. reset_n low mid-WAIT with x=4 -> immediately x=0, y=0, busy=0, move_count=0, at_end=0; first IDLE after release accepts a new press.
2. At (0,0) press RIGHT (4'b0100), floor -> address=1 and busy=1 after E0; x=1 at E0+3; busy=0; move_count=1.
3. At (1,0) press DOWN, data=1 -> address=11; position stays (1,0); move_count stays 1; busy high for exactly 3 cycles.
4. At (0,0) press LEFT, then 4'b0101 -> no address change, busy stays 0. Hold RIGHT 40 cycles -> one move without macro; with macro and REPEAT_DELAY=8, moves at E0+3, then every 12 cycles.
5. At (9,8) press DOWN, floor -> y=9 at E0+3; at_end=1 for one cycle at E0+4 with position (0,0); UP/RIGHT presses then ignored; at_start returns to IDLE and move_count=0.
6. at_start asserted at E0+1 of a floor read -> position (0,0), busy=0, move_count unchanged by the aborted read.
